// File: rtl/fsm_req_master.sv
// Requester agent: takes one job, drives req_N to the arbiter, holds for len+1 granted beats, then releases.
// Registered outputs; job_ready is high only in IDLE, so jobs offered while busy are dropped.
module fsm_req_master #(
  parameter int TIMEOUT = 16,
  parameter int LEN_W   = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [1:0]       job_src_i,
  input  logic [LEN_W-1:0] job_len_i,
  output logic             req_0_o,
  output logic             req_1_o,
  output logic             req_2_o,
  output logic             req_3_o,
  input  logic             gnt_0_i,
  input  logic             gnt_1_i,
  input  logic             gnt_2_i,
  input  logic             gnt_3_i,
  output logic             owner_vld_o,
  output logic [1:0]       owner_id_o,
  output logic             done_o,
  output logic             err_o,
  output logic             err_multi_o
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_REL
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         src_q, src_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               from_err_q, from_err_d;
  logic [3:0]         req_q, req_d;
  logic               owner_q, owner_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               multi_q;

  logic [3:0] gnt_vec;
  logic       gnt_src;
  logic       gnt_multi;

  assign gnt_vec   = {gnt_3_i, gnt_2_i, gnt_1_i, gnt_0_i};
  assign gnt_src   = gnt_vec[src_q];
  // Clearing the lowest set bit leaves something only if two or more grants are high.
  assign gnt_multi = (gnt_vec & (gnt_vec - 4'd1)) != 4'd0;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    from_err_d = from_err_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid_i && ready_q) begin
          state_d    = S_REQ;
          src_d      = job_src_i;
          len_d      = job_len_i;
          wait_d     = '0;
          from_err_d = 1'b0;
        end
      end
      S_REQ: begin
        if (gnt_src) begin
          state_d = S_HOLD;
          beat_d  = len_q;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_HOLD: begin
        // A lost grant outranks the last beat: the bus was not actually held.
        if (!gnt_src) begin
          state_d    = S_REL;
          err_d      = 1'b1;
          from_err_d = 1'b1;
          wait_d     = '0;
        end else if (beat_q == '0) begin
          state_d = S_REL;
          wait_d  = '0;
        end else begin
          beat_d = beat_q - 1'b1;
        end
      end
      S_REL: begin
        if (!gnt_src) begin
          state_d = S_IDLE;
          done_d  = !from_err_q;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d   = ((state_d == S_REQ) || (state_d == S_HOLD)) ? (4'b0001 << src_d) : 4'b0000;
    owner_d = (state_d == S_HOLD);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      from_err_q <= 1'b0;
      req_q      <= '0;
      owner_q    <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      from_err_q <= from_err_d;
      req_q      <= req_d;
      owner_q    <= owner_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      multi_q    <= multi_q | gnt_multi;
    end
  end

  assign req_0_o     = req_q[0];
  assign req_1_o     = req_q[1];
  assign req_2_o     = req_q[2];
  assign req_3_o     = req_q[3];
  assign owner_vld_o = owner_q;
  assign owner_id_o  = src_q;
  assign job_ready_o = ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_multi_o = multi_q;

endmodule

// File: tb/tb_fsm_req_master.sv
// Directed bench for fsm_req_master: a phase/age model checked every cycle, plus literal
// pulse and level counts per scenario.
module tb_fsm_req_master;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       job_valid = 1'b0;
  logic       job_ready;
  logic [1:0] job_src = 2'd0;
  logic [3:0] job_len = 4'd0;
  logic       req_0, req_1, req_2, req_3;
  logic       gnt_0 = 1'b0, gnt_1 = 1'b0, gnt_2 = 1'b0, gnt_3 = 1'b0;
  logic       owner_vld;
  logic [1:0] owner_id;
  logic       done, err, err_multi;

  always #5 clk = ~clk;

  fsm_req_master #(.TIMEOUT(TO), .LEN_W(4)) dut (
    .clk_i(clk), .reset_i(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_src_i(job_src), .job_len_i(job_len),
    .req_0_o(req_0), .req_1_o(req_1), .req_2_o(req_2), .req_3_o(req_3),
    .gnt_0_i(gnt_0), .gnt_1_i(gnt_1), .gnt_2_i(gnt_2), .gnt_3_i(gnt_3),
    .owner_vld_o(owner_vld), .owner_id_o(owner_id),
    .done_o(done), .err_o(err), .err_multi_o(err_multi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 idle, 1 requesting, 2 holding, 3 releasing; age counts cycles spent in the phase.
  int         m_ph = 0;
  int         m_age = 0;
  int         m_len = 0;
  logic [1:0] m_src = 2'd0;
  logic       m_via_err = 1'b0;
  logic       e_ready = 1'b0, e_done = 1'b0, e_err = 1'b0, e_multi = 1'b0;

  int hi_req[4];
  int hi_own, hi_done, hi_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [3:0] g;
    g = {gnt_3, gnt_2, gnt_1, gnt_0};
    if (rst) begin
      m_ph = 0; m_age = 0; m_len = 0; m_src = 2'd0; m_via_err = 1'b0;
      e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_multi = 1'b0;
    end else begin
      e_done = 1'b0;
      e_err  = 1'b0;
      if ($countones(g) > 1) e_multi = 1'b1;
      case (m_ph)
        0: if (job_valid && e_ready) begin
             m_ph = 1; m_src = job_src; m_len = int'(job_len); m_age = 0;
           end
        1: if (g[m_src]) begin m_ph = 2; m_age = 0; end
           else if (m_age == TO - 1) begin m_ph = 0; e_err = 1'b1; end
           else m_age++;
        2: if (!g[m_src]) begin m_ph = 3; m_age = 0; m_via_err = 1'b1; e_err = 1'b1; end
           else if (m_age == m_len) begin m_ph = 3; m_age = 0; m_via_err = 1'b0; end
           else m_age++;
        default: if (!g[m_src]) begin m_ph = 0; e_done = !m_via_err; end
           else if (m_age == TO - 1) begin m_ph = 0; e_err = 1'b1; end
           else m_age++;
      endcase
      e_ready = (m_ph == 0);
    end
  endtask

  // One clock: model advances on the rising edge, outputs are compared on the falling edge.
  task automatic step();
    logic [10:0] act, exp;
    logic [3:0]  e_req;
    logic        e_own;
    @(posedge clk);
    model_update();
    @(negedge clk);
    e_own = (m_ph == 2);
    e_req = (m_ph == 1 || m_ph == 2) ? (4'b0001 << m_src) : 4'b0000;
    act = {req_3, req_2, req_1, req_0, owner_vld, owner_id & {2{owner_vld}},
           job_ready, done, err, err_multi};
    exp = {e_req, e_own, m_src & {2{e_own}}, e_ready, e_done, e_err, e_multi};
    check("cycle", 32'(act), 32'(exp));
    if (req_0) hi_req[0]++;
    if (req_1) hi_req[1]++;
    if (req_2) hi_req[2]++;
    if (req_3) hi_req[3]++;
    if (owner_vld) hi_own++;
    if (done) hi_done++;
    if (err) hi_err++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) hi_req[i] = 0;
    hi_own = 0; hi_done = 0; hi_err = 0;
  endtask

  task automatic offer(input logic [1:0] s, input logic [3:0] l);
    job_valid = 1'b1; job_src = s; job_len = l;
    step();
    job_valid = 1'b0;
  endtask

  initial begin
    clr();
    steps(3);
    check("rst_ready", 32'(job_ready), 0);
    check("rst_req", 32'({req_3, req_2, req_1, req_0}), 0);
    check("rst_multi", 32'(err_multi), 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(job_ready), 1);

    // Grant two cycles after req_2, four held beats, clean release.
    clr();
    offer(2'd2, 4'd3);
    step();
    gnt_2 = 1'b1;
    steps(2);
    check("owner_id_hold", 32'(owner_id), 2);
    steps(3);
    gnt_2 = 1'b0;
    step();
    check("t1_done_now", 32'(done), 1);
    check("t1_ready", 32'(job_ready), 1);
    steps(2);
    check("t1_req2_cycles", 32'(hi_req[2]), 6);
    check("t1_owner_cycles", 32'(hi_own), 4);
    check("t1_done_count", 32'(hi_done), 1);
    check("t1_err_count", 32'(hi_err), 0);

    // No grant: request timeout; a job offered while busy is ignored.
    clr();
    offer(2'd0, 4'd0);
    step();
    job_valid = 1'b1; job_src = 2'd3;
    step();
    job_valid = 1'b0;
    steps(16);
    check("t2_req0_cycles", 32'(hi_req[0]), 16);
    check("t2_req3_cycles", 32'(hi_req[3]), 0);
    check("t2_err_count", 32'(hi_err), 1);
    check("t2_done_count", 32'(hi_done), 0);
    check("t2_ready", 32'(job_ready), 1);

    // Grant lost on the third hold beat.
    clr();
    offer(2'd1, 4'd7);
    gnt_1 = 1'b1;
    steps(3);
    gnt_1 = 1'b0;
    step();
    check("t3_err_now", 32'(err), 1);
    check("t3_req1_now", 32'(req_1), 0);
    steps(3);
    check("t3_owner_cycles", 32'(hi_own), 3);
    check("t3_err_count", 32'(hi_err), 1);
    check("t3_done_count", 32'(hi_done), 0);

    // Single-beat hold, grant stuck high: release timeout.
    clr();
    offer(2'd3, 4'd0);
    gnt_3 = 1'b1;
    steps(22);
    gnt_3 = 1'b0;
    steps(2);
    check("t4_owner_cycles", 32'(hi_own), 1);
    check("t4_req3_cycles", 32'(hi_req[3]), 2);
    check("t4_err_count", 32'(hi_err), 1);
    check("t4_done_count", 32'(hi_done), 0);

    // Two grants in one cycle set the sticky flag.
    check("t5_multi_before", 32'(err_multi), 0);
    gnt_0 = 1'b1; gnt_1 = 1'b1;
    step();
    gnt_0 = 1'b0; gnt_1 = 1'b0;
    check("t5_multi_set", 32'(err_multi), 1);
    steps(5);
    check("t5_multi_sticky", 32'(err_multi), 1);

    // Reset mid-hold; a job offered during reset is not taken.
    offer(2'd2, 4'd7);
    gnt_2 = 1'b1;
    steps(2);
    rst = 1'b1; gnt_2 = 1'b0;
    job_valid = 1'b1; job_src = 2'd1; job_len = 4'd2;
    step();
    check("t6_req2_rst", 32'(req_2), 0);
    check("t6_owner_rst", 32'(owner_vld), 0);
    check("t6_multi_rst", 32'(err_multi), 0);
    step();
    rst = 1'b0; job_valid = 1'b0;
    step();
    check("t6_ready", 32'(job_ready), 1);
    check("t6_no_req", 32'({req_3, req_2, req_1, req_0}), 0);
    steps(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
